// File: rtl/led_sequencer_if.sv
// LED sequencer control/status bundle: enable and mode in, LED drive and step pulse out.
// Latency: none, wires only.
// Backpressure: none; the sequencer free-runs whenever en is high.
interface led_sequencer_if #(
    parameter int NUM_LEDS = 8
);
    logic                en;
    logic [1:0]          mode;
    logic [NUM_LEDS-1:0] led;
    logic                step_pulse;

    // Controller side: drives enable/mode, observes LEDs
    modport master (
        output en,
        output mode,
        input  led,
        input  step_pulse
    );

    // Sequencer side
    modport slave (
        input  en,
        input  mode,
        output led,
        output step_pulse
    );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern generator: prescaled step tick advances walk-down/walk-up/bounce/blink patterns.
// Latency: led and step_pulse update one clk after the step condition (count==STEP_CYCLES-1 with en).
// Backpressure: none; en=0 freezes the prescaler and all pattern state.
module led_sequencer #(
    parameter int NUM_LEDS    = 8,
    parameter int STEP_CYCLES = 25000000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    led_sequencer_if.slave    bus
);
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [CW-1:0]       LAST_CNT = CW'(STEP_CYCLES - 1);
    localparam logic [PW-1:0]       TOP_POS  = PW'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] UNLIT    = ACTIVE_LOW ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}};

    typedef enum logic [1:0] {
        MODE_DOWN   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    logic [CW-1:0]       r_cnt;
    logic [PW-1:0]       r_pos;
    logic                r_dir_up;
    logic                r_phase_on;
    logic                r_running;
    mode_e               r_cur_mode;
    logic [NUM_LEDS-1:0] r_led;
    logic                r_step_pulse;

    logic [CW-1:0]       w_cnt_nxt;
    logic [PW-1:0]       w_pos_nxt;
    logic                w_dir_up_nxt;
    logic                w_phase_on_nxt;
    logic                w_running_nxt;
    mode_e               w_cur_mode_nxt;
    logic [NUM_LEDS-1:0] w_led_nxt;
    logic                w_step;
    mode_e               w_mode;

    assign w_step = bus.en && (r_cnt == LAST_CNT);
    assign w_mode = mode_e'(bus.mode);

    // State register: prescaler, position/direction/phase, and the registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_pos        <= TOP_POS;
            r_dir_up     <= 1'b0;
            r_phase_on   <= 1'b1;
            r_running    <= 1'b0;
            r_cur_mode   <= MODE_DOWN;
            r_led        <= UNLIT;
            r_step_pulse <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_pos        <= w_pos_nxt;
            r_dir_up     <= w_dir_up_nxt;
            r_phase_on   <= w_phase_on_nxt;
            r_running    <= w_running_nxt;
            r_cur_mode   <= w_cur_mode_nxt;
            r_step_pulse <= w_step;
            if (w_step) begin
                r_led <= w_led_nxt;
            end
        end
    end

    // Next state: prescaler count, then on a step either load the mode start state or advance
    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_pos_nxt      = r_pos;
        w_dir_up_nxt   = r_dir_up;
        w_phase_on_nxt = r_phase_on;
        w_running_nxt  = r_running;
        w_cur_mode_nxt = r_cur_mode;

        if (bus.en) begin
            w_cnt_nxt = (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
        end

        if (w_step) begin
            if (!r_running || (w_mode != r_cur_mode)) begin
                // Fresh start or mode switch: restart the newly sampled pattern
                w_running_nxt  = 1'b1;
                w_cur_mode_nxt = w_mode;
                case (w_mode)
                    MODE_DOWN:   w_pos_nxt = TOP_POS;
                    MODE_UP:     w_pos_nxt = '0;
                    MODE_BOUNCE: begin
                        w_pos_nxt    = TOP_POS;
                        w_dir_up_nxt = 1'b0;
                    end
                    default:     w_phase_on_nxt = 1'b1;
                endcase
            end else begin
                case (r_cur_mode)
                    MODE_DOWN:   w_pos_nxt = (r_pos == '0) ? TOP_POS : r_pos - 1'b1;
                    MODE_UP:     w_pos_nxt = (r_pos == TOP_POS) ? '0 : r_pos + 1'b1;
                    MODE_BOUNCE: begin
                        // Ends are turned around in one step so they are not shown twice
                        if (NUM_LEDS == 1) begin
                            w_pos_nxt = '0;
                        end else if (!r_dir_up) begin
                            if (r_pos == '0) begin
                                w_dir_up_nxt = 1'b1;
                                w_pos_nxt    = PW'(1);
                            end else begin
                                w_pos_nxt = r_pos - 1'b1;
                            end
                        end else begin
                            if (r_pos == TOP_POS) begin
                                w_dir_up_nxt = 1'b0;
                                w_pos_nxt    = TOP_POS - 1'b1;
                            end else begin
                                w_pos_nxt = r_pos + 1'b1;
                            end
                        end
                    end
                    default:     w_phase_on_nxt = ~r_phase_on;
                endcase
            end
        end
    end

    // Pattern from the next state, with board polarity applied
    always_comb begin
        w_led_nxt = '0;
        if (w_cur_mode_nxt == MODE_BLINK) begin
            w_led_nxt = {NUM_LEDS{w_phase_on_nxt}};
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                w_led_nxt[i] = (w_pos_nxt == PW'(i));
            end
        end
        if (ACTIVE_LOW) begin
            w_led_nxt = ~w_led_nxt;
        end
    end

    assign bus.led        = r_led;
    assign bus.step_pulse = r_step_pulse;
endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: per-cycle vector table across four parameter sets.
// Latency: expectations are sampled 1 time unit after each rising edge.
// Backpressure: n/a; stimulus only toggles en/mode/rst.
module tb_led_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_sequencer_if #(.NUM_LEDS(4)) if0 ();
    led_sequencer_if #(.NUM_LEDS(4)) if1 ();
    led_sequencer_if #(.NUM_LEDS(4)) if2 ();
    led_sequencer_if #(.NUM_LEDS(1)) if3 ();

    led_sequencer #(.NUM_LEDS(4), .STEP_CYCLES(3), .ACTIVE_LOW(1'b1)) u_main (.i_clk(clk), .i_rst(rst), .bus(if0));
    led_sequencer #(.NUM_LEDS(4), .STEP_CYCLES(3), .ACTIVE_LOW(1'b0)) u_al0  (.i_clk(clk), .i_rst(rst), .bus(if1));
    led_sequencer #(.NUM_LEDS(4), .STEP_CYCLES(1), .ACTIVE_LOW(1'b1)) u_s1   (.i_clk(clk), .i_rst(rst), .bus(if2));
    led_sequencer #(.NUM_LEDS(1), .STEP_CYCLES(3), .ACTIVE_LOW(1'b1)) u_n1   (.i_clk(clk), .i_rst(rst), .bus(if3));

    typedef struct {
        int       sel;
        bit       rst;
        bit       en;
        bit [1:0] mode;
        bit [3:0] exp_led;
        bit       exp_pulse;
    } vec_t;

    vec_t     vecs[$];
    int       g_sel;
    bit [3:0] g_led;
    int       n_total = 0;
    int       n_pass  = 0;

    logic [3:0] act_led;
    logic       act_pulse;
    int         cur_sel = 0;

    always_comb begin
        act_led   = 4'b0000;
        act_pulse = 1'b0;
        case (cur_sel)
            0:       begin act_led = if0.led;         act_pulse = if0.step_pulse; end
            1:       begin act_led = if1.led;         act_pulse = if1.step_pulse; end
            2:       begin act_led = if2.led;         act_pulse = if2.step_pulse; end
            default: begin act_led = {3'b000, if3.led}; act_pulse = if3.step_pulse; end
        endcase
    end

    task automatic push(input bit r, input bit e, input bit [1:0] m, input bit [3:0] l, input bit p);
        vec_t v;
        v.sel = g_sel; v.rst = r; v.en = e; v.mode = m; v.exp_led = l; v.exp_pulse = p;
        vecs.push_back(v);
        g_led = l;
    endtask

    // One full step period for STEP_CYCLES=3: two holding cycles then the step
    task automatic add_step(input bit [1:0] m, input bit [3:0] l);
        push(1'b0, 1'b1, m, g_led, 1'b0);
        push(1'b0, 1'b1, m, g_led, 1'b0);
        push(1'b0, 1'b1, m, l, 1'b1);
    endtask

    task automatic drive(input int sel, input bit e, input bit [1:0] m);
        if0.en = 1'b0; if1.en = 1'b0; if2.en = 1'b0; if3.en = 1'b0;
        case (sel)
            0:       begin if0.en = e; if0.mode = m; end
            1:       begin if1.en = e; if1.mode = m; end
            2:       begin if2.en = e; if2.mode = m; end
            default: begin if3.en = e; if3.mode = m; end
        endcase
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s [%0d]: got %0h, expected %0h", nm, idx, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        bit found;
        int n;
        if0.en = 1'b0; if0.mode = 2'b00;
        if1.en = 1'b0; if1.mode = 2'b00;
        if2.en = 1'b0; if2.mode = 2'b00;
        if3.en = 1'b0; if3.mode = 2'b00;

        // Main DUT: reset, walk-down with wrap
        g_sel = 0;
        push(1'b1, 1'b1, 2'b00, 4'b1111, 1'b0);
        push(1'b1, 1'b1, 2'b00, 4'b1111, 1'b0);
        add_step(2'b00, 4'b0111); add_step(2'b00, 4'b1011); add_step(2'b00, 4'b1101);
        add_step(2'b00, 4'b1110); add_step(2'b00, 4'b0111);
        // Walk-up, then bounce switched mid-run
        add_step(2'b01, 4'b1110); add_step(2'b01, 4'b1101); add_step(2'b01, 4'b1011);
        add_step(2'b01, 4'b0111); add_step(2'b01, 4'b1110);
        add_step(2'b10, 4'b0111); add_step(2'b10, 4'b1011); add_step(2'b10, 4'b1101);
        add_step(2'b10, 4'b1110); add_step(2'b10, 4'b1101); add_step(2'b10, 4'b1011);
        add_step(2'b10, 4'b0111); add_step(2'b10, 4'b1011);
        // Blink
        add_step(2'b11, 4'b0000); add_step(2'b11, 4'b1111); add_step(2'b11, 4'b0000);
        // Enable hold: one counted cycle, 10 frozen, then only the remaining count
        push(1'b0, 1'b1, 2'b11, 4'b0000, 1'b0);
        for (int i = 0; i < 10; i++) push(1'b0, 1'b0, 2'b11, 4'b0000, 1'b0);
        push(1'b0, 1'b1, 2'b11, 4'b0000, 1'b0);
        push(1'b0, 1'b1, 2'b11, 4'b1111, 1'b1);
        // Mode wiggle between steps is ignored
        push(1'b0, 1'b1, 2'b01, 4'b1111, 1'b0);
        push(1'b0, 1'b1, 2'b01, 4'b1111, 1'b0);
        push(1'b0, 1'b1, 2'b11, 4'b0000, 1'b1);
        // Reset on a would-be step cycle while showing 1101, then restart
        add_step(2'b00, 4'b0111); add_step(2'b00, 4'b1011); add_step(2'b00, 4'b1101);
        push(1'b0, 1'b1, 2'b00, 4'b1101, 1'b0);
        push(1'b0, 1'b1, 2'b00, 4'b1101, 1'b0);
        push(1'b1, 1'b1, 2'b00, 4'b1111, 1'b0);
        add_step(2'b00, 4'b0111);

        // ACTIVE_LOW=0: blink then walk-down
        g_sel = 1;
        push(1'b1, 1'b0, 2'b00, 4'b0000, 1'b0);
        push(1'b1, 1'b0, 2'b00, 4'b0000, 1'b0);
        add_step(2'b11, 4'b1111); add_step(2'b11, 4'b0000); add_step(2'b11, 4'b1111);
        add_step(2'b00, 4'b1000); add_step(2'b00, 4'b0100);

        // STEP_CYCLES=1: every enabled cycle steps
        g_sel = 2;
        push(1'b1, 1'b0, 2'b00, 4'b1111, 1'b0);
        push(1'b0, 1'b1, 2'b00, 4'b0111, 1'b1);
        push(1'b0, 1'b1, 2'b00, 4'b1011, 1'b1);
        push(1'b0, 1'b1, 2'b00, 4'b1101, 1'b1);
        push(1'b0, 1'b0, 2'b00, 4'b1101, 1'b0);
        push(1'b0, 1'b0, 2'b00, 4'b1101, 1'b0);
        push(1'b0, 1'b1, 2'b00, 4'b1110, 1'b1);
        push(1'b0, 1'b1, 2'b00, 4'b0111, 1'b1);

        // NUM_LEDS=1 bounce: the single LED stays lit
        g_sel = 3;
        push(1'b1, 1'b0, 2'b10, 4'b0001, 1'b0);
        add_step(2'b10, 4'b0000); add_step(2'b10, 4'b0000); add_step(2'b10, 4'b0000);

        foreach (vecs[k]) begin
            cur_sel = vecs[k].sel;
            rst     = vecs[k].rst;
            drive(vecs[k].sel, vecs[k].en, vecs[k].mode);
            @(posedge clk);
            #1;
            check("led", k, {28'd0, act_led}, {28'd0, vecs[k].exp_led});
            check("step_pulse", k, {31'd0, act_pulse}, {31'd0, vecs[k].exp_pulse});
        end

        // Hand-written: main DUT from reset-idle, first walk-up step latency and pulse width
        cur_sel = 0;
        rst     = 1'b0;
        drive(0, 1'b1, 2'b01);
        found = 1'b0;
        n     = 0;
        for (int i = 1; i <= 6 && !found; i++) begin
            @(posedge clk);
            #1;
            if (if0.step_pulse) begin
                found = 1'b1;
                n     = i;
            end
        end
        check("first_step_latency", 0, n, 3);
        check("first_walkup_led", 0, {28'd0, if0.led}, 32'h0000000e);
        @(posedge clk);
        #1;
        check("pulse_one_cycle", 0, {31'd0, if0.step_pulse}, 32'd0);
        check("led_holds", 0, {28'd0, if0.led}, 32'h0000000e);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
